basic_sys: RTL and testbench



---
 rtl/basic_sys.sv | 144 ++++++++++++++
 tb/tb_basic_sys.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/basic_sys.sv
// Basic system top: emulated DCM lock/reset generator plus a small switch-to-LED
// I/O controller standing in for the Picoblaze program.

module syscon #(
    parameter int LOCK_CYCLES = 64
) (
    input  logic CLK_IN,
    input  logic RESET_IN,
    output logic LOCKED,
    output logic sys_rst
);
    localparam int CW = $clog2(LOCK_CYCLES + 1);

    logic [CW-1:0] lock_cnt;
    logic [1:0]    rst_sync;
    logic          rst_any;

    // Down-counter: LOCKED rises on the LOCK_CYCLES-th edge after reset release.
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            lock_cnt <= CW'(LOCK_CYCLES - 1);
            LOCKED   <= 1'b0;
        end else if (!LOCKED) begin
            if (lock_cnt == '0)
                LOCKED <= 1'b1;
            else
                lock_cnt <= lock_cnt - 1'b1;
        end
    end

    assign rst_any = RESET_IN | ~LOCKED;

    // Asserts immediately, releases two edges after lock.
    always_ff @(posedge CLK_IN or posedge rst_any) begin
        if (rst_any)
            rst_sync <= 2'b11;
        else
            rst_sync <= {rst_sync[0], 1'b0};
    end

    assign sys_rst = rst_sync[1];
endmodule

// state | meaning
// RST   | held in internal reset, LEDS dark
// WAIT  | start-up pause after internal reset clears
// ALIVE | write the alive pattern once
// READ  | capture synchronised switches
// WRITE | drive captured switches plus alive bit to LEDS
module basic_sys #(
    parameter int         LOCK_CYCLES    = 64,
    parameter int         STARTUP_CYCLES = 16,
    parameter logic [7:0] ALIVE_MASK     = 8'h80
) (
    input  logic       CLK_IN,
    input  logic       RESET_IN,
    input  logic [7:0] SWITCHES,
    output logic [7:0] LEDS
);
    localparam int SW = $clog2(STARTUP_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_RST,
        ST_WAIT,
        ST_ALIVE,
        ST_READ,
        ST_WRITE
    } state_t;

    logic          LOCKED;
    logic          sys_rst;
    logic [7:0]    sw_meta, sw_sync;
    state_t        state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [7:0]    leds_q, leds_d;
    logic [7:0]    in_q, in_d;

    syscon #(.LOCK_CYCLES(LOCK_CYCLES)) syscon (
        .CLK_IN   (CLK_IN),
        .RESET_IN (RESET_IN),
        .LOCKED   (LOCKED),
        .sys_rst  (sys_rst)
    );

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            sw_meta <= 8'h00;
            sw_sync <= 8'h00;
        end else begin
            sw_meta <= SWITCHES;
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge CLK_IN or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_RST;
            cnt_q   <= '0;
            leds_q  <= 8'h00;
            in_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            leds_q  <= leds_d;
            in_q    <= in_d;
        end
    end

    // The RST->WAIT edge is the second start-up cycle counted from sys_rst release,
    // so the timer is loaded two short of STARTUP_CYCLES.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        leds_d  = leds_q;
        in_d    = in_q;
        case (state_q)
            ST_RST: begin
                cnt_d   = SW'(STARTUP_CYCLES - 2);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0)
                    state_d = ST_ALIVE;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            ST_ALIVE: begin
                leds_d  = ALIVE_MASK;
                state_d = ST_READ;
            end
            ST_READ: begin
                in_d    = sw_sync;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                leds_d  = in_q | ALIVE_MASK;
                state_d = ST_READ;
            end
            default: state_d = ST_RST;
        endcase
    end

    assign LEDS = leds_q;
endmodule

// File: tb/tb_basic_sys.sv
// Scoreboard bench for basic_sys: expected LED updates are queued with a cycle
// window and a monitor checks every observed LEDS change against the queue.

module tb_basic_sys;
    logic       CLK_IN   = 1'b0;
    logic       RESET_IN = 1'b1;
    logic [7:0] SWITCHES = 8'h00;
    logic [7:0] LEDS;

    basic_sys dut (
        .CLK_IN   (CLK_IN),
        .RESET_IN (RESET_IN),
        .SWITCHES (SWITCHES),
        .LEDS     (LEDS)
    );

    always #5 CLK_IN = ~CLK_IN;

    int cyc = 0;
    always @(posedge CLK_IN) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] val;
        int         lo;
        int         hi;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_leds = 8'h00;
    logic [7:0] prev_leds = 8'h00;
    bit         mon_en = 1'b0;
    int         lk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input logic [7:0] v, input int lo, input int hi);
        q.push_back('{v, lo, hi});
        exp_leds = v;
    endtask

    always @(negedge CLK_IN) begin
        exp_t e;
        if (mon_en && LEDS !== prev_leds) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_leds: got %h want %h (cycle %0d)", LEDS, prev_leds, cyc);
            end else begin
                e = q.pop_front();
                chk("leds_value", {24'h0, LEDS}, {24'h0, e.val});
                total++;
                if (cyc < e.lo || cyc > e.hi) begin
                    bad++;
                    $display("FAIL leds_timing: got cycle %0d want %0d..%0d", cyc, e.lo, e.hi);
                end
            end
        end
        prev_leds = LEDS;
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK_IN);
        #2;
    endtask

    // Expected lock 64 edges after release, alive pattern 19 edges after lock.
    task automatic wait_lock(input bit toggle, output int l);
        int rel;
        rel = cyc;
        l = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK_IN);
            if (dut.syscon.LOCKED === 1'b1) begin
                l = cyc;
                break;
            end
            chk("leds_dark_before_lock", {24'h0, LEDS}, 32'h0);
            if (toggle) begin
                #2;
                SWITCHES = 8'($urandom);
            end
        end
        chk("lock_latency", l - rel, 64);
        if (l >= 0)
            push(8'h80, l + 19, l + 19);
    endtask

    task automatic set_sw(input logic [7:0] v);
        logic [7:0] nv;
        SWITCHES = v;
        nv = v | 8'h80;
        if (nv != exp_leds)
            push(nv, cyc + 1, cyc + 5);
    endtask

    // First WRITE after ALIVE lands two edges later.
    task automatic after_alive(input int l);
        logic [7:0] nv;
        nv = SWITCHES | 8'h80;
        if (nv != 8'h80)
            push(nv, l + 21, l + 21);
    endtask

    task automatic do_reset(input int n);
        RESET_IN = 1'b1;
        if (exp_leds != 8'h00)
            push(8'h00, cyc, cyc + 1);
        #1;
        chk("async_leds_reset", {24'h0, LEDS}, 32'h0);
        chk("async_locked_reset", {31'h0, dut.syscon.LOCKED}, 32'h0);
        step(n);
        chk("leds_held_in_reset", {24'h0, LEDS}, 32'h0);
        RESET_IN = 1'b0;
    endtask

    initial begin
        #50;
        prev_leds = LEDS;
        mon_en = 1'b1;
        #100;
        chk("leds_in_reset", {24'h0, LEDS}, 32'h0);
        chk("locked_in_reset", {31'h0, dut.syscon.LOCKED}, 32'h0);
        #500;
        chk("leds_in_reset_late", {24'h0, LEDS}, 32'h0);
        chk("locked_in_reset_late", {31'h0, dut.syscon.LOCKED}, 32'h0);
        #450;
        RESET_IN = 1'b0;
        wait_lock(1'b0, lk);
        step(119);
        chk("alive_only", {24'h0, LEDS}, 32'h80);

        set_sw(8'hFF);
        step(10);
        chk("all_on", {24'h0, LEDS}, 32'hFF);
        set_sw(8'hA5);
        step(8);
        chk("pattern_a5", {24'h0, LEDS}, 32'hA5);
        set_sw(8'h00);
        step(8);
        chk("back_to_alive", {24'h0, LEDS}, 32'h80);

        for (int i = 0; i < 24; i++) begin
            set_sw(8'($urandom));
            step($urandom_range(6, 12));
        end

        set_sw(8'hFF);
        step(8);
        do_reset(3);
        wait_lock(1'b0, lk);
        after_alive(lk);
        step(30);
        chk("ff_after_reset", {24'h0, LEDS}, 32'hFF);

        do_reset(3);
        wait_lock(1'b1, lk);
        for (int i = 0; i < 12; i++) begin
            step(1);
            SWITCHES = 8'($urandom);
        end
        after_alive(lk);
        step(30);
        chk("final_switch_value", {24'h0, LEDS}, {24'h0, SWITCHES | 8'h80});
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
